// File: rtl/fusion_accumulator.sv
// fusion_accumulator
//   Accumulates the packed 64-bit product word of the bit-fusion multiplier
//   into up to four lane sums per dot-product group. The lane layout is
//   decoded from {cfga,cfgb}. The beat flagged last closes the group. The
//   finished sums are then held behind a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready product beat handshake
//   in_data           packed product word
//   in_cfga/in_cfgb   precision config of the beat
//   in_signed         beat signedness (sa|sb)
//   in_last           final beat of the group
//   out_valid/ready   result handshake
//   out_acc           lane sums, lane k at [k*ACC_W +: ACC_W]
//   out_lanes         active lane count (1, 2 or 4)
//   out_beats         beats accumulated in the group (saturating)
//   cfg_err           sticky illegal/changed cfg flag

// Per-lane next-value logic: a load, or a wrap/clamp add.
module fusion_acc_lane #(
    parameter int ACC_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] addend,
    input  logic             grp_signed,
    input  logic             load,
    output logic [ACC_W-1:0] nxt
);
    logic [ACC_W:0] s_sum;
    logic [ACC_W:0] u_sum;

    always_comb begin
        s_sum = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
        u_sum = {1'b0, acc} + {1'b0, addend};
        nxt   = u_sum[ACC_W-1:0];
        if (load) begin
            nxt = addend;
        end else if (SATURATE != 0) begin
            if (grp_signed) begin
                // The sign of the extra bit disagrees with the MSB only on overflow.
                if (s_sum[ACC_W] != s_sum[ACC_W-1])
                    nxt = s_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
            end else if (u_sum[ACC_W]) begin
                nxt = '1;
            end
        end
    end
endmodule

module fusion_accumulator #(
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [63:0]        in_data,
    input  logic [1:0]         in_cfga,
    input  logic [1:0]         in_cfgb,
    input  logic               in_signed,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] out_acc,
    output logic [2:0]         out_lanes,
    output logic [CNT_W-1:0]   out_beats,
    output logic               cfg_err
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t state, state_nxt;

    logic [NUM_LANES-1:0][ACC_W-1:0] acc;
    logic [NUM_LANES-1:0][ACC_W-1:0] acc_nxt;
    logic [NUM_LANES-1:0][ACC_W-1:0] contrib;
    logic [3:0]                      beat_cfg;
    logic [3:0]                      grp_cfg;
    logic                            grp_signed;
    logic [2:0]                      beat_lanes;
    logic [2:0]                      use_lanes;
    logic                            beat_illegal;
    logic                            accept;
    logic                            load;

    function automatic logic [ACC_W-1:0] ext32(input logic [31:0] x, input logic s);
        logic [ACC_W-1:0] r;
        for (int i = 0; i < ACC_W; i++)
            r[i] = (i < 32) ? x[i % 32] : (s & x[31]);
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] ext16(input logic [15:0] x, input logic s);
        logic [ACC_W-1:0] r;
        for (int i = 0; i < ACC_W; i++)
            r[i] = (i < 16) ? x[i % 16] : (s & x[15]);
        return r;
    endfunction

    assign beat_cfg = {in_cfga, in_cfgb};

    // Lane count of the beat's own cfg; 0 marks an illegal code.
    always_comb begin
        beat_lanes = 3'd0;
        case (beat_cfg)
            4'b1010:                                  beat_lanes = 3'd1;
            4'b1001, 4'b0110:                         beat_lanes = 3'd2;
            4'b1000, 4'b0010, 4'b0101,
            4'b0100, 4'b0001, 4'b0000:                beat_lanes = 3'd4;
            default:                                  beat_lanes = 3'd0;
        endcase
    end

    assign beat_illegal = (beat_lanes == 3'd0);

    // The first beat of a group decodes with its own cfg. An illegal first
    // cfg opens a 1-lane group. Later beats decode with the latched layout.
    assign use_lanes = load ? (beat_illegal ? 3'd1 : beat_lanes) : out_lanes;

    always_comb begin
        contrib = '0;
        if (!beat_illegal) begin
            case (use_lanes)
                3'd1: contrib[0] = ext32(in_data[31:0], in_signed);
                3'd2: begin
                    contrib[0] = ext32(in_data[31:0],  in_signed);
                    contrib[1] = ext32(in_data[63:32], in_signed);
                end
                default: begin
                    contrib[0] = ext16(in_data[15:0],  in_signed);
                    contrib[1] = ext16(in_data[31:16], in_signed);
                    contrib[2] = ext16(in_data[47:32], in_signed);
                    contrib[3] = ext16(in_data[63:48], in_signed);
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fusion_acc_lane #(.ACC_W(ACC_W), .SATURATE(SATURATE)) u_lane (
            .acc        (acc[k]),
            .addend     (contrib[k]),
            .grp_signed (grp_signed),
            .load       (load),
            .nxt        (acc_nxt[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // In DRAIN a beat can only be taken with the result handshake. Such a
    // beat opens the next group directly, with no idle cycle between.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (in_valid) state_nxt = in_last ? DRAIN : ACCUM;
            end
            DRAIN: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready)
                    state_nxt = in_valid ? (in_last ? DRAIN : ACCUM) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign load   = accept && (state != ACCUM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            grp_cfg    <= '0;
            grp_signed <= 1'b0;
            out_lanes  <= '0;
            out_beats  <= '0;
            cfg_err    <= 1'b0;
        end else if (accept) begin
            acc <= acc_nxt;
            if (load) begin
                grp_cfg    <= beat_cfg;
                grp_signed <= in_signed;
                out_lanes  <= beat_illegal ? 3'd1 : beat_lanes;
                out_beats  <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (out_beats != '1) begin
                out_beats <= out_beats + 1'b1;
            end
            if (beat_illegal || (!load && beat_cfg != grp_cfg))
                cfg_err <= 1'b1;
        end
    end

    assign out_acc = acc;
endmodule

// File: tb/tb_fusion_accumulator.sv
module tb_fusion_accumulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, in_signed, in_last, out_ready;
    logic [63:0] in_data;
    logic [1:0]  in_cfga, in_cfgb;

    logic         rdy0, rdy1, rdy2, ov0, ov1, ov2, err0, err1, err2;
    logic [127:0] acc0;
    logic [63:0]  acc1, acc2;
    logic [2:0]   ln0, ln1, ln2;
    logic [15:0]  bt0, bt1, bt2;

    fusion_accumulator u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_cfga(in_cfga), .in_cfgb(in_cfgb), .in_signed(in_signed), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_acc(acc0), .out_lanes(ln0),
        .out_beats(bt0), .cfg_err(err0));

    fusion_accumulator #(.ACC_W(16), .SATURATE(1)) u16s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_cfga(in_cfga), .in_cfgb(in_cfgb), .in_signed(in_signed), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_acc(acc1), .out_lanes(ln1),
        .out_beats(bt1), .cfg_err(err1));

    fusion_accumulator #(.ACC_W(16), .SATURATE(0)) u16w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .in_cfga(in_cfga), .in_cfgb(in_cfgb), .in_signed(in_signed), .in_last(in_last),
        .out_valid(ov2), .out_ready(out_ready), .out_acc(acc2), .out_lanes(ln2),
        .out_beats(bt2), .cfg_err(err2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int      W[3] = '{32, 16, 16};
    bit      S[3] = '{1'b0, 1'b1, 1'b0};
    longint  m_acc[3][4];
    int      m_lanes, m_beats;
    bit      m_sgn, m_err, m_valid, m_open;
    logic [3:0] m_code;

    function automatic int lanes_of(input logic [3:0] c);
        case (c)
            4'b1010:                                          return 1;
            4'b1001, 4'b0110:                                 return 2;
            4'b1000, 4'b0010, 4'b0101, 4'b0100, 4'b0001, 4'b0000: return 4;
            default:                                          return 0;
        endcase
    endfunction

    function automatic longint wrapw(input longint x, input int w);
        return x & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint interp(input longint u, input int w, input bit sg);
        if (sg && u[w-1]) return u - (longint'(1) << w);
        return u;
    endfunction

    // Lane k of a word split into `lanes` equal fields, as a signed or unsigned integer.
    function automatic longint field(input logic [63:0] d, input int lanes, input int k, input bit sg);
        int fw;
        longint raw;
        if (k >= lanes) return 0;
        fw  = (lanes == 4) ? 16 : 32;
        raw = longint'((d >> (k * fw)) & ((64'd1 << fw) - 64'd1));
        if (sg && raw[fw-1]) raw = raw - (longint'(1) << fw);
        return raw;
    endfunction

    task automatic model_beat(input logic [63:0] d, input logic [3:0] code, input bit sg, input bit last);
        int nl;
        bit ill;
        longint v, a, b, s, lo, hi;
        nl  = lanes_of(code);
        ill = (nl == 0);
        if (ill) m_err = 1'b1;
        if (!m_open) begin
            m_code  = code;
            m_lanes = ill ? 1 : nl;
            m_sgn   = sg;
            m_beats = 1;
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 4; k++)
                    m_acc[i][k] = ill ? 0 : wrapw(field(d, m_lanes, k, sg), W[i]);
        end else begin
            if (code != m_code) m_err = 1'b1;
            if (m_beats < 65535) m_beats++;
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 4; k++) begin
                    v = ill ? 0 : wrapw(field(d, m_lanes, k, sg), W[i]);
                    if (S[i]) begin
                        a  = interp(m_acc[i][k], W[i], m_sgn);
                        b  = interp(v, W[i], m_sgn);
                        s  = a + b;
                        lo = m_sgn ? -(longint'(1) << (W[i] - 1)) : 0;
                        hi = m_sgn ? (longint'(1) << (W[i] - 1)) - 1 : (longint'(1) << W[i]) - 1;
                        if (s < lo) s = lo;
                        if (s > hi) s = hi;
                        m_acc[i][k] = wrapw(s, W[i]);
                    end else begin
                        m_acc[i][k] = wrapw(m_acc[i][k] + v, W[i]);
                    end
                end
        end
        m_open = !last;
    endtask

    task automatic model_reset();
        m_valid = 0; m_open = 0; m_err = 0; m_lanes = 0; m_beats = 0; m_sgn = 0; m_code = '0;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) m_acc[i][k] = 0;
    endtask

    // One lockstep cycle. It is called just after a falling edge and
    // returns at the next falling edge.
    task automatic cycle(input bit v, input logic [63:0] d, input logic [3:0] code,
                         input bit sg, input bit last, input bit ordy);
        bit erdy, acc, hs, nv;
        chk("out_valid", longint'({ov0, ov1, ov2}), m_valid ? 7 : 0);
        chk("cfg_err", longint'({err0, err1, err2}), m_err ? 7 : 0);
        if (m_valid) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("acc32_l%0d", k),  longint'(acc0[k*32 +: 32]), m_acc[0][k]);
                chk($sformatf("acc16s_l%0d", k), longint'(acc1[k*16 +: 16]), m_acc[1][k]);
                chk($sformatf("acc16w_l%0d", k), longint'(acc2[k*16 +: 16]), m_acc[2][k]);
            end
            chk("out_lanes", longint'(ln0), longint'(m_lanes));
            chk("out_beats", longint'(bt0), longint'(m_beats));
            chk("out_lanes16", longint'({ln1, ln2}), longint'({3'(m_lanes), 3'(m_lanes)}));
            chk("out_beats16", longint'({bt1, bt2}), longint'({16'(m_beats), 16'(m_beats)}));
        end
        in_valid = v; in_data = d; {in_cfga, in_cfgb} = code;
        in_signed = sg; in_last = last; out_ready = ordy;
        #1;
        erdy = !m_valid || ordy;
        chk("in_ready", longint'({rdy0, rdy1, rdy2}), erdy ? 7 : 0);
        acc = v && erdy;
        hs  = m_valid && ordy;
        nv  = m_valid;
        if (acc) model_beat(d, code, sg, last);
        if (hs) nv = 0;
        if (acc && last) nv = 1;
        m_valid = nv;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("rst_out_valid", longint'({ov0, ov1, ov2}), 0);
        chk("rst_out_acc", longint'((|acc0) | (|acc1) | (|acc2)), 0);
        chk("rst_out_lanes", longint'({ln0, ln1, ln2}), 0);
        chk("rst_out_beats", longint'({bt0, bt1, bt2}), 0);
        chk("rst_cfg_err", longint'({err0, err1, err2}), 0);
    endtask

    typedef struct {
        logic [63:0] d;
        logic [3:0]  code;
        bit          sg;
        bit          last;
        bit          check;
        logic [31:0] e0, e1, e2, e3;
        int          lanes;
        int          beats;
    } vec_t;

    vec_t tbl[6];

    logic [3:0] legal[9] = '{4'b1010, 4'b1001, 4'b0110, 4'b1000, 4'b0010,
                             4'b0101, 4'b0100, 4'b0001, 4'b0000};

    initial begin
        logic [3:0]  cur_code;
        bit          cur_sg;
        logic [63:0] rd;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFD, 4'b1010, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFD, 4'b1010, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFD, 4'b1010, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7, 32'h0, 32'h0, 32'h0, 1, 3};
        tbl[3] = '{64'h03FF_0007_0005_0003, 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
        tbl[4] = '{64'h03FF_0007_0005_0003, 4'b1000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd10, 32'd14, 32'h7FE, 4, 2};
        tbl[5] = '{64'hFFFF_FFF0_0000_0010, 4'b1001, 1'b1, 1'b1, 1'b1, 32'd16, 32'hFFFF_FFF0, 32'h0, 32'h0, 2, 1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cfga = '0; in_cfgb = '0;
        in_signed = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Spec vectors. Each row after a result handshakes it and starts the next group.
        for (int r = 0; r < 6; r++) begin
            cycle(1'b1, tbl[r].d, tbl[r].code, tbl[r].sg, tbl[r].last, 1'b1);
            if (tbl[r].check) begin
                chk($sformatf("vec%0d_valid", r), longint'(ov0), 1);
                chk($sformatf("vec%0d_l0", r), longint'(acc0[31:0]),  longint'(tbl[r].e0));
                chk($sformatf("vec%0d_l1", r), longint'(acc0[63:32]), longint'(tbl[r].e1));
                chk($sformatf("vec%0d_l2", r), longint'(acc0[95:64]), longint'(tbl[r].e2));
                chk($sformatf("vec%0d_l3", r), longint'(acc0[127:96]), longint'(tbl[r].e3));
                chk($sformatf("vec%0d_lanes", r), longint'(ln0), longint'(tbl[r].lanes));
                chk($sformatf("vec%0d_beats", r), longint'(bt0), longint'(tbl[r].beats));
                chk($sformatf("vec%0d_err", r), longint'(err0), 0);
            end
        end

        // Saturation versus wrap on a signed 4-lane group.
        cycle(1'b1, 64'h7000, 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 64'h7000, 4'b0000, 1'b1, 1'b1, 1'b1);
        chk("sat16_l0", longint'(acc1[15:0]), 64'h7FFF);
        chk("wrap16_l0", longint'(acc2[15:0]), 64'hE000);
        chk("wide32_l0", longint'(acc0[31:0]), 64'hE000);
        cycle(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Backpressure in DRAIN, then a beat accepted with the handshake.
        cycle(1'b1, 64'h0000_0000_1234_5678, 4'b1010, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 64'hAAAA, 4'b1010, 1'b0, 1'b1, 1'b0);
            chk("bp_hold_acc", longint'(acc0[31:0]), 64'h1234_5678);
            chk("bp_hold_valid", longint'(ov0), 1);
        end
        cycle(1'b1, 64'h10, 4'b1010, 1'b0, 1'b0, 1'b1);
        chk("bp_new_open", longint'(ov0), 0);
        cycle(1'b1, 64'h20, 4'b1010, 1'b0, 1'b1, 1'b1);
        chk("bp_next_acc", longint'(acc0[31:0]), 64'h30);
        chk("bp_next_beats", longint'(bt0), 2);
        cycle(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // A cfg change mid-group is flagged and decoded with the latched 1-lane layout.
        cycle(1'b1, 64'h5, 4'b1010, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'h0001_0002_0003_0004, 4'b0000, 1'b0, 1'b1, 1'b1);
        chk("cfgchg_err", longint'(err0), 1);
        chk("cfgchg_l0", longint'(acc0[31:0]), 64'h0003_0009);
        chk("cfgchg_upper", longint'(|acc0[127:32]), 0);
        chk("cfgchg_lanes", longint'(ln0), 1);
        cycle(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // An illegal code contributes nothing but still counts and closes the group.
        do_reset();
        cycle(1'b1, 64'h7, 4'b1010, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1111, 1'b0, 1'b1, 1'b1);
        chk("illegal_l0", longint'(acc0[31:0]), 7);
        chk("illegal_err", longint'(err0), 1);
        chk("illegal_beats", longint'(bt0), 2);
        cycle(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // A reset in mid-group discards the partial sums.
        do_reset();
        cycle(1'b1, 64'h100, 4'b1010, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 64'h100, 4'b1010, 1'b0, 1'b0, 1'b1);
        do_reset();
        cycle(1'b1, 64'h3, 4'b1010, 1'b0, 1'b1, 1'b1);
        chk("postrst_l0", longint'(acc0[31:0]), 3);
        chk("postrst_beats", longint'(bt0), 1);
        chk("postrst_err", longint'(err0), 0);
        cycle(1'b0, 64'h0, 4'b0000, 1'b0, 1'b0, 1'b1);

        // Random traffic checked against the model every cycle.
        cur_code = 4'b1010;
        cur_sg   = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            if (!m_open) begin
                cur_code = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15))
                                                        : legal[$urandom_range(0, 8)];
                cur_sg   = 1'($urandom_range(0, 1));
            end
            rd = {$urandom, $urandom};
            cycle($urandom_range(0, 3) != 0, rd,
                  ($urandom_range(0, 19) == 0) ? legal[$urandom_range(0, 8)] : cur_code,
                  cur_sg, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fusion_accumulator.md
Name: fusion_accumulator

Overview:
- Downstream stage of the bit-fusion multiplier array: consumes the packed 64-bit product word and its {cfga,cfgb} mode, and accumulates one partial sum per active lane across a dot-product group.
- On the beat flagged last, it presents the finished per-lane sums with a valid/ready handshake, then clears for the next group.
- Sits between the fusion multiplier and the output/requantization path of a PE.

Parameters:
- ACC_W, 32, width of each lane accumulator and each output lane (16..48).
- CNT_W, 16, width of the beat counter.
- SATURATE, 0, 0 = two's-complement wrap, 1 = clamp to the lane min/max.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  product beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  64  packed product word from the fusion multiplier
- in_cfga  in  2  precision config of operand a for this beat
- in_cfgb  in  2  precision config of operand b for this beat
- in_signed  in  1  beat is signed (sa|sb of the multiplier)
- in_last  in  1  final beat of the group
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_acc  out  4*ACC_W  lane sums; lane k at [k*ACC_W +: ACC_W]
- out_lanes  out  3  active lane count: 1, 2 or 4
- out_beats  out  CNT_W  beats accumulated in the group (saturating)
- cfg_err  out  1  sticky flag: illegal or changed cfg seen; cleared only by reset

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, out_acc=0, out_lanes=0, out_beats=0, cfg_err=0.
  - All four accumulators and the beat counter are cleared; state goes to IDLE.
  - Reset takes effect mid-group or mid-drain; the partial group is discarded.
- Lane decode from {cfga,cfgb}:
  - 1010: 1 lane = in_data[31:0].
  - 1001 and 0110: 2 lanes = [31:0] and [63:32].
  - 1000, 0010, 0101, 0100, 0001, 0000: 4 lanes = 16-bit fields [15:0], [31:16], [47:32], [63:48].
  - Any other code is illegal.
- Extension to ACC_W:
  - 16-bit lanes are sign-extended when in_signed=1, otherwise zero-extended.
  - 32-bit lanes are sign- or zero-extended, or truncated, to ACC_W by the same rule.
  - Inactive lanes contribute 0 and their outputs read 0.
- States:
  - IDLE: no group in progress.
  - ACCUM: group open.
  - DRAIN: result held.
- IDLE:
  - in_ready=1.
  - An accepted beat latches cfg as the group cfg, loads the accumulators with the beat lanes, and sets beat count to 1.
  - Goes to DRAIN if in_last, else to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted beat adds its lanes, decoded with the latched group cfg, and increments the count.
  - in_last goes to DRAIN.
  - A beat whose cfg differs from the latched cfg sets cfg_err and is still accumulated under the latched cfg.
- Illegal cfg on any accepted beat:
  - sets cfg_err and contributes 0 to every lane;
  - still increments the count;
  - still honours in_last.
  - In IDLE, an illegal cfg latches a 1-lane group.
- DRAIN:
  - out_valid=1; out_acc, out_lanes and out_beats are registered and stable until the handshake.
  - Result appears the cycle after the last beat is accepted (latency 1).
  - in_ready = out_ready. A beat accepted in the same cycle as the output handshake starts a new group as from IDLE (no bubble).
  - Handshake with no accepted beat goes to IDLE.
- Arithmetic:
  - SATURATE=0: ACC_W-bit wrap.
  - SATURATE=1, signed group: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SATURATE=1, unsigned group: clamp to [0, 2^ACC_W-1].
  - The group signedness is latched on the first beat.
- out_beats saturates at 2^CNT_W-1.
- Outputs never change while out_valid=1 and out_ready=0.
- No combinational path from in_data to any output.

Test Plan:
- Signed mode 1010, three beats of 64'hFFFF_FFFF_FFFF_FFFD, the third with last, out_ready=1 -> one cycle after the third accept: out_valid=1, lane0=32'hFFFF_FFF7 (-9), lanes 1-3=0, out_lanes=1, out_beats=3.
- Unsigned mode 1000, two beats of 64'h03FF_0007_0005_0003, last on the second -> lanes = 6, 10, 14, 0x7FE; out_lanes=4.
- Signed mode 1001, single beat {32'hFFFF_FFF0, 32'h0000_0010} with last -> lane0=16, lane1=-16, out_beats=1; cfg_err stays 0.
- Backpressure: hold out_ready=0 for 5 cycles in DRAIN while in_valid=1 -> in_ready=0 and out_acc stable. Then raise out_ready with a new beat present -> same-cycle handshake, the new group starts, next result correct.
- ACC_W=16, SATURATE=1, signed 4-lane: two beats of lane0=16'h7000 -> lane0=16'h7FFF. With SATURATE=0 -> lane0=16'hE000.
- Cfg change mid-group (1010 then 0000) -> cfg_err=1, second beat decoded as 1 lane. Illegal code 1111 beat -> cfg_err=1, lanes unchanged. Reset asserted mid-ACCUM -> next group result excludes the pre-reset beats and cfg_err=0.
